spike_window_counter: RTL and testbench

SPIKE_WINDOW_COUNTER -- requirements
Module: spike_window_counter

---
 rtl/spike_window_counter_pkg.sv | 6 +
 rtl/spike_window_counter_popcount.sv | 13 +
 rtl/spike_window_counter.sv | 78 +++++++
 tb/tb_spike_window_counter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/spike_window_counter_pkg.sv
// spike_window_counter_pkg: shared FSM encoding and default widths for the spike counting path
package spike_window_counter_pkg;
   localparam int DEF_N_NEURONS = 32;
   localparam int DEF_CNT_W     = 32;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/spike_window_counter_popcount.sv
// spike_popcount: combinational count of set bits in the per-cycle spike vector
module spike_popcount #(
   parameter int N_NEURONS = 32,
   parameter int CNT_W     = 32
) (
   input  logic [N_NEURONS-1:0] spikes_i,
   output logic [CNT_W-1:0]     cnt_o
);
   always_comb begin
      cnt_o = '0;
      for (int j = 0; j < N_NEURONS; j++) cnt_o = cnt_o + CNT_W'(spikes_i[j]);
   end
endmodule

// File: rtl/spike_window_counter.sv
// spike_window_counter: accumulates pool spikes over a programmable window and hands the count downstream
module spike_window_counter
   import spike_window_counter_pkg::*;
#(
   parameter int N_NEURONS = DEF_N_NEURONS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_en,
   input  logic [N_NEURONS-1:0] i_spikes,
   input  logic [31:0]          i_window_len,
   output logic [CNT_W-1:0]     o_spike_cnt,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_overrun
);
   state_e            state_q, state_d;
   logic [31:0]       len_q, len_d, timer_q, timer_d, len_in;
   logic [CNT_W-1:0]  acc_q, acc_d, cnt_q, cnt_d, pop, sat;
   logic [CNT_W:0]    sum_w;
   logic              valid_q, valid_d, ovr_q, ovr_d;
   logic              start, run_en, last, restart;

   spike_popcount #(.N_NEURONS(N_NEURONS), .CNT_W(CNT_W)) u_pop (
      .spikes_i (i_spikes),
      .cnt_o    (pop)
   );

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb state_d = (state_q == IDLE && i_en) ? RUN : state_q;

   always_comb begin
      start  = (state_q == IDLE) && i_en;
      run_en = (state_q == RUN) && i_en;
   end

   // carry out of the widened sum marks saturation
   always_comb begin
      sum_w   = {1'b0, acc_q} + {1'b0, pop};
      sat     = sum_w[CNT_W] ? '1 : sum_w[CNT_W-1:0];
      last    = run_en && (timer_q == len_q - 32'd1);
      restart = start || last;
      len_in  = (i_window_len == 32'd0) ? 32'd1 : i_window_len;
      len_d   = restart ? len_in : len_q;
      timer_d = restart ? 32'd0 : run_en ? timer_q + 32'd1 : timer_q;
      acc_d   = restart ? '0 : run_en ? sat : acc_q;
      cnt_d   = last ? sat : cnt_q;
      valid_d = last ? 1'b1 : (valid_q && i_ready) ? 1'b0 : valid_q;
      ovr_d   = ovr_q || (last && valid_q && !i_ready);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         len_q   <= 32'd1;
         timer_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         len_q   <= len_d;
         timer_q <= timer_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign o_spike_cnt = cnt_q;
   assign o_valid     = valid_q;
   assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_spike_window_counter.sv
// tb_spike_window_counter: directed and random checks of both a 32-bit and an 8-bit counter against a window model
module tb_spike_window_counter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_en = 1'b0;
   logic [31:0] i_spikes = '0;
   logic [31:0] i_window_len = 32'd1;
   logic        i_ready = 1'b0;
   logic [31:0] cnt32;
   logic [7:0]  cnt8;
   logic        valid32, valid8, ovr32, ovr8;

   int n_assert = 0;
   int n_fail   = 0;

   bit     m_run;
   int     m_len;
   int     m_win[$];
   longint m_res;
   bit     m_valid, m_ovr;

   always #5 clk = ~clk;

   spike_window_counter dut32 (
      .clk(clk), .reset(reset), .i_en(i_en), .i_spikes(i_spikes), .i_window_len(i_window_len),
      .o_spike_cnt(cnt32), .o_valid(valid32), .i_ready(i_ready), .o_overrun(ovr32)
   );

   spike_window_counter #(.N_NEURONS(32), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .i_en(i_en), .i_spikes(i_spikes), .i_window_len(i_window_len),
      .o_spike_cnt(cnt8), .o_valid(valid8), .i_ready(i_ready), .o_overrun(ovr8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // window model: a window is the list of popcounts seen on enabled cycles, closed when it holds L entries
   task automatic model_edge(input logic rstn, input logic en, input logic [31:0] sp,
                             input logic rdy, input logic [31:0] len);
      longint s;
      bit load;
      if (!rstn) begin
         m_run = 0; m_len = 1; m_win.delete(); m_res = 0; m_valid = 0; m_ovr = 0;
         return;
      end
      if (!m_run) begin
         if (en) begin
            m_run = 1; m_len = (len == 0) ? 1 : int'(len); m_win.delete();
         end
         return;
      end
      load = 0;
      s = 0;
      if (en) begin
         m_win.push_back($countones(sp));
         if (m_win.size() == m_len) begin
            foreach (m_win[k]) s += m_win[k];
            load = 1;
            m_win.delete();
            m_len = (len == 0) ? 1 : int'(len);
         end
      end
      if (load) begin
         if (m_valid && !rdy) m_ovr = 1;
         m_res = s;
         m_valid = 1;
      end else if (m_valid && rdy) m_valid = 0;
   endtask

   task automatic step(input logic rstn, input logic en, input logic [31:0] sp,
                       input logic rdy, input logic [31:0] len);
      logic [63:0] e32, e8;
      @(negedge clk);
      reset = rstn; i_en = en; i_spikes = sp; i_ready = rdy; i_window_len = len;
      @(posedge clk);
      model_edge(rstn, en, sp, rdy, len);
      #1;
      e32 = (m_res > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_res;
      e8  = (m_res > 255) ? 64'd255 : m_res;
      check("valid32", 64'(valid32), 64'(m_valid));
      check("cnt32", 64'(cnt32), e32);
      check("ovr32", 64'(ovr32), 64'(m_ovr));
      check("valid8", 64'(valid8), 64'(m_valid));
      check("cnt8", 64'(cnt8), e8);
      check("ovr8", 64'(ovr8), 64'(m_ovr));
   endtask

   initial begin
      step(0, 0, 0, 0, 4);
      step(0, 0, 0, 0, 4);
      check("rst_valid", 64'(valid32), 64'd0);
      check("rst_cnt", 64'(cnt32), 64'd0);
      check("rst_ovr", 64'(ovr32), 64'd0);

      // L=4, 4 spikes per cycle, results on edges 5, 9, 13 after entering
      for (int e = 1; e <= 13; e++) begin
         step(1, 1, 32'h0000_000F, 1, 4);
         if (e == 5 || e == 9 || e == 13) begin
            check("w4_valid", 64'(valid32), 64'd1);
            check("w4_cnt", 64'(cnt32), 64'd16);
         end
         if (e == 6) check("w4_valid_clr", 64'(valid32), 64'd0);
      end
      check("w4_ovr", 64'(ovr32), 64'd0);

      // L=3, downstream stalled for two windows
      step(0, 0, 0, 0, 3);
      for (int e = 1; e <= 7; e++) step(1, 1, 32'h0000_0100, 0, 3);
      check("stall_valid", 64'(valid32), 64'd1);
      check("stall_cnt", 64'(cnt32), 64'd3);
      check("stall_ovr", 64'(ovr32), 64'd1);

      // L=5 with a 3-cycle enable gap
      step(0, 0, 0, 0, 5);
      step(1, 1, 32'h3, 1, 5);
      for (int e = 0; e < 2; e++) step(1, 1, 32'h3, 1, 5);
      for (int e = 0; e < 3; e++) step(1, 0, 32'hFFFF_FFFF, 1, 5);
      for (int e = 0; e < 2; e++) step(1, 1, 32'h3, 1, 5);
      check("gap_pending", 64'(valid32), 64'd0);
      step(1, 1, 32'h3, 1, 5);
      check("gap_valid", 64'(valid32), 64'd1);
      check("gap_cnt", 64'(cnt32), 64'd10);

      // window length changed mid-window
      step(0, 0, 0, 0, 4);
      step(1, 1, 32'h1, 1, 4);
      for (int e = 0; e < 2; e++) step(1, 1, 32'h1, 1, 4);
      step(1, 1, 32'h1, 1, 2);
      check("len_hold", 64'(valid32), 64'd0);
      step(1, 1, 32'h1, 1, 2);
      check("len_first", 64'(cnt32), 64'd4);
      step(1, 1, 32'h1, 1, 2);
      check("len_mid", 64'(valid32), 64'd0);
      step(1, 1, 32'h1, 1, 2);
      check("len_next_valid", 64'(valid32), 64'd1);
      check("len_next_cnt", 64'(cnt32), 64'd2);

      // saturation of the 8-bit counter
      step(0, 0, 0, 0, 10);
      for (int e = 0; e <= 10; e++) step(1, 1, 32'hFFFF_FFFF, 1, 10);
      check("sat8", 64'(cnt8), 64'd255);
      check("sat32", 64'(cnt32), 64'd320);

      // reset mid-window discards the partial count
      step(0, 0, 0, 0, 4);
      step(1, 1, 32'h0000_000F, 1, 4);
      for (int e = 0; e < 2; e++) step(1, 1, 32'h0000_000F, 1, 4);
      step(0, 1, 32'h0000_000F, 1, 4);
      check("midrst_valid", 64'(valid32), 64'd0);
      check("midrst_cnt", 64'(cnt32), 64'd0);
      step(1, 1, 32'h0000_000F, 1, 4);
      for (int e = 0; e < 4; e++) step(1, 1, 32'h0000_000F, 1, 4);
      check("midrst_next", 64'(cnt32), 64'd16);

      for (int e = 0; e < 400; e++)
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 6));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
